mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-003 SHALL have port Instr, input, 32, current instruction held in the datapath IR (written only when IRWrite=1).
REQ-004 SHALL have port Equal, input, 1, datapath comparator result (ReadGF1 == ReadGF2).
REQ-005 SHALL have port IRWrite, output, 1, IR load enable.
REQ-006 SHALL have port PCWrite, output, 1, PC load enable.
REQ-007 SHALL have port NPCsel, output, 2: 0 = PC+4, 1 = PC + sext(imm16)<<2, 2 = {PC[31:28], imm26, 2'b0}, 3 = ReadGF1.
REQ-008 SHALL have port WEgf, output, 1, register-file write enable.
REQ-009 SHALL have port RegDst, output, 2: 0 = rt, 1 = rd, 2 = 5'd31.
REQ-010 SHALL have port WDsel, output, 2: 0 = ALU result, 1 = DM read data, 2 = PC, 3 = {imm16, 16'b0}.
REQ-011 SHALL have port WEdm, output, 1, data-memory write enable.
REQ-012 SHALL have port ALUSrc, output, 2: 0 = ReadGF2, 1 = zext(imm16), 2 = sext(imm16).
REQ-013 SHALL have port ALUopcode, output, 4: 0 = add, 1 = sub, 3 = or.
REQ-014 SHALL have port state, output, 3, current FSM state (debug).
REQ-015 SHALL have port InstrCount, output, 32, count of retired instructions.

Function
REQ-016 SHALL decode addu, subu (op 0, func 100001/100011), lui 001111, ori 001101, lw 100011, sw 101011, beq 000100, jal 000011, jr (op 0, func 001000), j 000010; any other encoding, including nop, is an unknown instruction.
REQ-017 SHALL implement FSM states FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4; encodings 5-7 SHALL transition to FETCH with all enables 0.
REQ-018 FETCH: IRWrite=1, PCWrite=1, NPCsel=0; next state DECODE, so PC holds fetch address + 4 from DECODE onward.
REQ-019 DECODE, j: PCWrite=1, NPCsel=2; next FETCH.
REQ-020 DECODE, jal: PCWrite=1, NPCsel=2, WEgf=1, RegDst=2, WDsel=2 (writes fetch address + 4); next FETCH.
REQ-021 DECODE, jr: PCWrite=1, NPCsel=3; next FETCH.
REQ-022 DECODE, unknown: no enables asserted; next FETCH.
REQ-023 DECODE, all other instructions: next EXE.
REQ-024 EXE: addu/subu SHALL drive ALUSrc=0 and ALUopcode 0/1; ori SHALL drive ALUSrc=1, ALUopcode=3; lw/sw SHALL drive ALUSrc=2, ALUopcode=0.
REQ-025 EXE, beq: ALUSrc=0, ALUopcode=1; PCWrite=Equal, NPCsel=1; next FETCH.
REQ-026 EXE transitions: lw/sw to MEM; addu/subu/ori/lui to WB.
REQ-027 MEM: the ALU operand selects of REQ-024 SHALL be held; sw SHALL assert WEdm=1 for exactly one cycle, next FETCH; lw next WB.
REQ-028 WB: WEgf=1; RegDst=1 for addu/subu, else 0; WDsel=0 for addu/subu/ori, 1 for lw, 3 for lui; next FETCH.
REQ-029 Outputs not listed for a state SHALL be 0; all outputs SHALL be combinational from the state register and Instr.
REQ-030 InstrCount SHALL increment by 1 (modulo 2^32, wrapping 0xFFFFFFFF to 0) on every transition into FETCH from a non-FETCH state, unknown instructions included.
REQ-031 Cycles per instruction: j/jal/jr/unknown 2, beq 3, sw 4, addu/subu/ori/lui 4, lw 5.

Reset
REQ-032 While reset=1: state=FETCH, InstrCount=0, and IRWrite, PCWrite, WEgf and WEdm are forced to 0, independent of clk.
REQ-033 Reset asserted mid-instruction SHALL abort that instruction with no further writes and no count increment; the first rising edge after deassertion SHALL perform FETCH.

Verification
REQ-034 addu $3,$1,$2 (0x00221821) after reset -> states 0,1,2,4,0; WEgf=1, RegDst=1, WDsel=0 only in WB; InstrCount becomes 1.
REQ-035 lw (0x8C220004) -> states 0,1,2,3,4,0; ALUSrc=2 in EXE and MEM; WB with WDsel=1, RegDst=0; WEdm=0 throughout.
REQ-036 beq with Equal=1 (0x10220003), then Equal=0 -> EXE has PCWrite=1, NPCsel=1, then PCWrite=0; 3 cycles each.
REQ-037 jal 0x0C000C00 -> DECODE has PCWrite=1, NPCsel=2, WEgf=1, RegDst=2, WDsel=2; next state FETCH.
REQ-038 Reset pulse while in MEM with sw -> WEdm=0 immediately, state=0, InstrCount=0; unknown 0xFFFFFFFF -> 2 cycles, no enables, count +1.
REQ-039 Force InstrCount to 0xFFFFFFFF, retire one j -> InstrCount=0.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle MIPS-subset control unit: five-state FSM that sequences the
// datapath enables and counts retired instructions.
`default_nettype none

module mc_control (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic        Equal,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic [1:0]  NPCsel,
   output logic        WEgf,
   output logic [1:0]  RegDst,
   output logic [1:0]  WDsel,
   output logic        WEdm,
   output logic [1:0]  ALUSrc,
   output logic [3:0]  ALUopcode,
   output logic [2:0]  state,
   output logic [31:0] InstrCount
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXE    = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   state_t      cur_state, next_state;
   logic [31:0] instr_count;
   logic        ir_we, pc_we, gf_we, dm_we;
   logic        unused_bits;

   logic [5:0] op, func;
   logic is_addu, is_subu, is_lui, is_ori, is_lw, is_sw;
   logic is_beq, is_jal, is_jr, is_j, is_known;

   assign op          = Instr[31:26];
   assign func        = Instr[5:0];
   assign unused_bits = ^Instr[25:6];

   assign is_addu  = (op == 6'b000000) && (func == 6'b100001);
   assign is_subu  = (op == 6'b000000) && (func == 6'b100011);
   assign is_jr    = (op == 6'b000000) && (func == 6'b001000);
   assign is_lui   = (op == 6'b001111);
   assign is_ori   = (op == 6'b001101);
   assign is_lw    = (op == 6'b100011);
   assign is_sw    = (op == 6'b101011);
   assign is_beq   = (op == 6'b000100);
   assign is_jal   = (op == 6'b000011);
   assign is_j     = (op == 6'b000010);
   assign is_known = is_addu | is_subu | is_jr | is_lui | is_ori | is_lw |
                     is_sw | is_beq | is_jal | is_j;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state   <= FETCH;
         instr_count <= 32'd0;
      end else begin
         cur_state <= next_state;
         if (cur_state != FETCH && next_state == FETCH)
            instr_count <= instr_count + 32'd1;
      end
   end

   always_comb begin
      next_state = FETCH;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      gf_we      = 1'b0;
      dm_we      = 1'b0;
      NPCsel     = 2'd0;
      RegDst     = 2'd0;
      WDsel      = 2'd0;
      ALUSrc     = 2'd0;
      ALUopcode  = 4'd0;
      case (cur_state)
         FETCH: begin
            ir_we      = 1'b1;
            pc_we      = 1'b1;
            next_state = DECODE;
         end
         DECODE: begin
            if (is_j) begin
               pc_we  = 1'b1;
               NPCsel = 2'd2;
            end else if (is_jal) begin
               pc_we  = 1'b1;
               NPCsel = 2'd2;
               gf_we  = 1'b1;
               RegDst = 2'd2;
               WDsel  = 2'd2;
            end else if (is_jr) begin
               pc_we  = 1'b1;
               NPCsel = 2'd3;
            end else if (is_known) begin
               next_state = EXE;
            end
         end
         EXE: begin
            if (is_subu || is_beq) ALUopcode = 4'd1;
            if (is_ori) begin
               ALUSrc    = 2'd1;
               ALUopcode = 4'd3;
            end
            if (is_lw || is_sw) ALUSrc = 2'd2;
            if (is_beq) begin
               pc_we  = Equal;
               NPCsel = 2'd1;
            end else if (is_lw || is_sw) begin
               next_state = MEM;
            end else if (is_addu || is_subu || is_ori || is_lui) begin
               next_state = WB;
            end
         end
         MEM: begin
            // keep the address calculation stable while memory is accessed
            ALUSrc = 2'd2;
            if (is_sw) dm_we = 1'b1;
            else if (is_lw) next_state = WB;
         end
         WB: begin
            gf_we = 1'b1;
            if (is_addu || is_subu) RegDst = 2'd1;
            if (is_lw) WDsel = 2'd1;
            else if (is_lui) WDsel = 2'd3;
         end
         default: next_state = FETCH;
      endcase
   end

   // write enables are suppressed asynchronously while reset is held
   assign IRWrite    = ir_we & ~reset;
   assign PCWrite    = pc_we & ~reset;
   assign WEgf       = gf_we & ~reset;
   assign WEdm       = dm_we & ~reset;
   assign state      = cur_state;
   assign InstrCount = instr_count;

endmodule

`default_nettype wire

// File: tb/tb_mc_control.sv
// Randomized self-checking bench for mc_control against an instruction-level model.
`default_nettype none

module tb_mc_control;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instr;
   logic        Equal;
   logic        IRWrite, PCWrite, WEgf, WEdm;
   logic [1:0]  NPCsel, RegDst, WDsel, ALUSrc;
   logic [3:0]  ALUopcode;
   logic [2:0]  state;
   logic [31:0] InstrCount;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_cnt;

   typedef enum int {C_ADDU, C_SUBU, C_LUI, C_ORI, C_LW, C_SW, C_BEQ,
                     C_JAL, C_JR, C_J, C_UNK} cls_t;

   mc_control dut (
      .clk(clk), .reset(reset), .Instr(Instr), .Equal(Equal),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .NPCsel(NPCsel), .WEgf(WEgf),
      .RegDst(RegDst), .WDsel(WDsel), .WEdm(WEdm), .ALUSrc(ALUSrc),
      .ALUopcode(ALUopcode), .state(state), .InstrCount(InstrCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] make_instr(input cls_t c);
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [25:0] tgt;
      logic [31:0] w;
      rs  = 5'($urandom);
      rt  = 5'($urandom);
      rd  = 5'($urandom);
      imm = 16'($urandom);
      tgt = 26'($urandom);
      case (c)
         C_ADDU: w = {6'b000000, rs, rt, rd, 5'd0, 6'b100001};
         C_SUBU: w = {6'b000000, rs, rt, rd, 5'd0, 6'b100011};
         C_LUI:  w = {6'b001111, 5'd0, rt, imm};
         C_ORI:  w = {6'b001101, rs, rt, imm};
         C_LW:   w = {6'b100011, rs, rt, imm};
         C_SW:   w = {6'b101011, rs, rt, imm};
         C_BEQ:  w = {6'b000100, rs, rt, imm};
         C_JAL:  w = {6'b000011, tgt};
         C_JR:   w = {6'b000000, rs, 15'd0, 6'b001000};
         C_J:    w = {6'b000010, tgt};
         default: begin
            case ($urandom_range(0, 3))
               0:       w = 32'h0000_0000;
               1:       w = 32'hFFFF_FFFF;
               2:       w = {6'b000101, rs, rt, imm};
               default: w = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
            endcase
         end
      endcase
      return w;
   endfunction

   // state walk of one instruction, taken from the cycles-per-instruction table
   function automatic int walk_len(input cls_t c);
      case (c)
         C_J, C_JAL, C_JR, C_UNK: return 2;
         C_BEQ:                   return 3;
         C_LW:                    return 5;
         default:                 return 4;
      endcase
   endfunction

   function automatic logic [2:0] walk_state(input cls_t c, input int k);
      if (k < 3) return 3'(k);
      if (c == C_LW) return (k == 3) ? 3'd3 : 3'd4;
      if (c == C_SW) return 3'd3;
      return 3'd4;
   endfunction

   // packed {IRWrite,PCWrite,NPCsel,WEgf,RegDst,WDsel,WEdm,ALUSrc,ALUopcode}
   function automatic logic [15:0] exp_out(input cls_t c, input logic [2:0] st, input logic eq);
      logic ir, pc, we, wd;
      logic [1:0] npc, rdst, wsel, asrc;
      logic [3:0] aop;
      ir = 0; pc = 0; we = 0; wd = 0;
      npc = 0; rdst = 0; wsel = 0; asrc = 0; aop = 0;
      if (st == 3'd0) begin
         ir = 1; pc = 1;
      end else if (st == 3'd1) begin
         if (c == C_J)   begin pc = 1; npc = 2; end
         if (c == C_JR)  begin pc = 1; npc = 3; end
         if (c == C_JAL) begin pc = 1; npc = 2; we = 1; rdst = 2; wsel = 2; end
      end else if (st == 3'd2) begin
         if (c == C_SUBU) aop = 1;
         if (c == C_ORI)  begin asrc = 1; aop = 3; end
         if (c == C_LW || c == C_SW) asrc = 2;
         if (c == C_BEQ)  begin aop = 1; pc = eq; npc = 1; end
      end else if (st == 3'd3) begin
         asrc = 2;
         wd = (c == C_SW);
      end else if (st == 3'd4) begin
         we = 1;
         rdst = (c == C_ADDU || c == C_SUBU) ? 2'd1 : 2'd0;
         wsel = (c == C_LW) ? 2'd1 : (c == C_LUI) ? 2'd3 : 2'd0;
      end
      return {ir, pc, npc, we, rdst, wsel, wd, asrc, aop};
   endfunction

   // called at a falling edge with the DUT in FETCH; returns at a falling edge in the next FETCH
   task automatic run_instr(input cls_t c, input logic [31:0] word, input int eqmode, input bit wrap);
      logic [2:0] st;
      logic [15:0] got;
      Instr = word;
      check("count_at_fetch", InstrCount, exp_cnt);
      if (wrap) begin
         force dut.instr_count = 32'hFFFF_FFFF;
         #1;
         release dut.instr_count;
         exp_cnt = 32'hFFFF_FFFF;
         check("count_forced", InstrCount, exp_cnt);
      end
      for (int k = 0; k < walk_len(c); k++) begin
         Equal = (eqmode == 2) ? 1'($urandom) : 1'(eqmode);
         #1;
         st  = walk_state(c, k);
         got = {IRWrite, PCWrite, NPCsel, WEgf, RegDst, WDsel, WEdm, ALUSrc, ALUopcode};
         check("state", 32'(state), 32'(st));
         check("outputs", 32'(got), 32'(exp_out(c, st, Equal)));
         @(posedge clk);
         @(negedge clk);
      end
      exp_cnt = exp_cnt + 32'd1;
      check("state_back_to_fetch", 32'(state), 32'd0);
   endtask

   initial begin
      cls_t c;
      reset = 1'b1;
      Instr = 32'h0;
      Equal = 1'b0;
      exp_cnt = 32'd0;
      repeat (2) @(negedge clk);
      check("reset_state", 32'(state), 32'd0);
      check("reset_count", InstrCount, 32'd0);
      check("reset_enables", {28'd0, IRWrite, PCWrite, WEgf, WEdm}, 32'd0);
      reset = 1'b0;
      #1;

      run_instr(C_ADDU, 32'h0022_1821, 0, 1'b0);
      check("count_after_addu", InstrCount, 32'd1);
      run_instr(C_LW,  32'h8C22_0004, 0, 1'b0);
      run_instr(C_BEQ, 32'h1022_0003, 1, 1'b0);
      run_instr(C_BEQ, 32'h1022_0003, 0, 1'b0);
      run_instr(C_JAL, 32'h0C00_0C00, 0, 1'b0);

      // abort a store while it is in MEM
      Instr = 32'hAC22_0004;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("sw_in_mem", {29'd0, state}, 32'd3);
      check("sw_wedm_before_abort", 32'(WEdm), 32'd1);
      reset = 1'b1;
      #1;
      check("abort_wedm", 32'(WEdm), 32'd0);
      check("abort_state", 32'(state), 32'd0);
      check("abort_count", InstrCount, 32'd0);
      check("abort_enables", {29'd0, IRWrite, PCWrite, WEgf}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_cnt = 32'd0;
      #1;
      run_instr(C_UNK, 32'hFFFF_FFFF, 2, 1'b0);
      check("count_after_unknown", InstrCount, 32'd1);

      run_instr(C_J, make_instr(C_J), 2, 1'b1);
      check("count_wrap", InstrCount, 32'd0);

      for (int i = 0; i < 80; i++) begin
         c = cls_t'($urandom_range(0, 10));
         run_instr(c, make_instr(c), 2, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
